// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter: grants one requester per cycle to a shared register bank
// and registers the one-hot write enable and data for the bank to capture next edge.
module reg_write_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 4,
    parameter int AW   = 2
) (
    input  logic                clk,
    input  logic                res,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*AW-1:0]  req_addr,
    input  logic [NREQ*8-1:0]   req_data,
    input  logic                hold,
    output logic [NREQ-1:0]     gnt,
    output logic [NREG-1:0]     reg_en,
    output logic [7:0]          reg_data,
    output logic                busy,
    output logic [7:0]          wr_count
);
    localparam int PW = $clog2(NREQ);

    logic [NREQ-1:0][AW-1:0] addr_a;
    logic [NREQ-1:0][7:0]    data_a;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           sel;
    logic [PW-1:0]           cand;
    logic                    sel_vld;

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign addr_a[i] = req_addr[i*AW +: AW];
            assign data_a[i] = req_data[i*8 +: 8];
        end
    endgenerate

    always_comb begin
        sel     = '0;
        sel_vld = 1'b0;
        cand    = '0;
        if (res && !hold) begin
            // Walk from the farthest slot to ptr so the nearest set request is the one kept.
            for (int off = NREQ - 1; off >= 0; off--) begin
                cand = PW'((int'(ptr) + off) % NREQ);
                if (req[cand]) begin
                    sel     = cand;
                    sel_vld = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (sel_vld) gnt[sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ptr      <= '0;
            reg_en   <= '0;
            reg_data <= 8'h00;
            busy     <= 1'b0;
            wr_count <= 8'h00;
        end else if (sel_vld) begin
            ptr      <= (sel == PW'(NREQ - 1)) ? '0 : sel + PW'(1);
            reg_en   <= NREG'(1) << addr_a[sel];
            reg_data <= data_a[sel];
            busy     <= 1'b1;
            wr_count <= wr_count + 8'd1;
        end else begin
            // reg_data deliberately holds; only the enable marks a valid write.
            reg_en <= '0;
            busy   <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized self-checking bench for reg_write_arbiter against a distance-based
// round-robin reference model.
module tb_reg_write_arbiter;
    localparam int NREQ = 4;
    localparam int NREG = 4;
    localparam int AW   = 2;

    logic             clk = 1'b0;
    logic             res;
    logic [NREQ-1:0]  req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*8-1:0]  req_data;
    logic             hold;
    logic [NREQ-1:0]  gnt;
    logic [NREG-1:0]  reg_en;
    logic [7:0]       reg_data;
    logic             busy;
    logic [7:0]       wr_count;

    int checks = 0;
    int errors = 0;

    int a_addr[NREQ];
    int a_data[NREQ];

    int         m_ptr, m_cnt, m_data, m_busy;
    logic [3:0] m_en;

    reg_write_arbiter #(.NREQ(NREQ), .NREG(NREG), .AW(AW)) dut (
        .clk(clk), .res(res), .req(req), .req_addr(req_addr), .req_data(req_data),
        .hold(hold), .gnt(gnt), .reg_en(reg_en), .reg_data(reg_data),
        .busy(busy), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    // Winner is the requester with the smallest circular distance from the pointer.
    function automatic int pick(logic [3:0] r, logic h);
        int best = -1;
        int bd = NREQ;
        if (h) return -1;
        for (int i = 0; i < NREQ; i++)
            if (r[i] && ((i - m_ptr + NREQ) % NREQ) < bd) begin
                bd   = (i - m_ptr + NREQ) % NREQ;
                best = i;
            end
        return best;
    endfunction

    function automatic logic [3:0] oh(int k);
        if (k < 0) return 4'b0000;
        return 4'(1 << k);
    endfunction

    task automatic mdl_reset();
        m_ptr = 0; m_cnt = 0; m_data = 0; m_busy = 0; m_en = 4'b0000;
    endtask

    task automatic mdl_edge(int k);
        if (k >= 0) begin
            m_en   = 4'(1 << a_addr[k]);
            m_data = a_data[k];
            m_busy = 1;
            m_cnt  = (m_cnt + 1) % 256;
            m_ptr  = (k + 1) % NREQ;
        end else begin
            m_en   = 4'b0000;
            m_busy = 0;
        end
    endtask

    task automatic new_payload();
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i] = int'($urandom_range(0, NREG - 1));
            a_data[i] = int'($urandom_range(0, 255));
        end
    endtask

    task automatic drive(logic [3:0] r, logic h);
        req  = r;
        hold = h;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = AW'(a_addr[i]);
            req_data[i*8 +: 8]   = 8'(a_data[i]);
        end
        #1;
    endtask

    task automatic test_reset();
        int k;
        res = 1'b0;
        mdl_reset();
        new_payload();
        drive(4'b1111, 1'b0);
        checks += 5;
        if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b exp 0000", gnt); end
        if (reg_en !== 4'b0000) begin errors++; $display("FAIL reset_en: got %b exp 0000", reg_en); end
        if (reg_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h exp 00", reg_data); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
        if (wr_count !== 8'h00) begin errors++; $display("FAIL reset_cnt: got %h exp 00", wr_count); end
        @(posedge clk); #1;
        res = 1'b1;
        drive(4'b0001, 1'b0);
        k = pick(4'b0001, 1'b0);
        checks++;
        if (gnt !== 4'b0001) begin errors++; $display("FAIL reset_release_gnt: got %b exp 0001", gnt); end
        @(posedge clk); mdl_edge(k); #1;
        a_addr[2] = 2;
        drive(4'b0100, 1'b0);
        k = pick(4'b0100, 1'b0);
        @(posedge clk); mdl_edge(k); #1;
        checks++;
        if (reg_en !== 4'b0100) begin errors++; $display("FAIL pre_reset_en: got %b exp 0100", reg_en); end
        #2 res = 1'b0;
        #1;
        mdl_reset();
        checks += 4;
        if (reg_en !== 4'b0000) begin errors++; $display("FAIL midreset_en: got %b exp 0000", reg_en); end
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b exp 0", busy); end
        if (wr_count !== 8'h00) begin errors++; $display("FAIL midreset_cnt: got %h exp 00", wr_count); end
        if (gnt !== 4'b0000) begin errors++; $display("FAIL midreset_gnt: got %b exp 0000", gnt); end
        @(posedge clk); #1;
        res = 1'b1;
        drive(4'b0000, 1'b0);
        @(posedge clk); mdl_edge(-1); #1;
        checks++;
        if (reg_en !== 4'b0000) begin errors++; $display("FAIL post_release_en: got %b exp 0000", reg_en); end
    endtask

    task automatic test_single();
        int k;
        a_addr[1] = 3;
        a_data[1] = 8'hA5;
        drive(4'b0010, 1'b0);
        k = pick(4'b0010, 1'b0);
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL single_gnt: got %b exp 0010", gnt); end
        @(posedge clk); mdl_edge(k); #1;
        drive(4'b0000, 1'b0);
        checks += 4;
        if (reg_en !== 4'b1000) begin errors++; $display("FAIL single_en: got %b exp 1000", reg_en); end
        if (reg_data !== 8'hA5) begin errors++; $display("FAIL single_data: got %h exp a5", reg_data); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
        if (wr_count !== 8'h01) begin errors++; $display("FAIL single_cnt: got %h exp 01", wr_count); end
    endtask

    task automatic test_round_robin();
        int k;
        new_payload();
        drive(4'b1000, 1'b0);
        k = pick(4'b1000, 1'b0);
        @(posedge clk); mdl_edge(k); #1;
        for (int i = 0; i < 8; i++) begin
            new_payload();
            drive(4'b1111, 1'b0);
            k = pick(4'b1111, 1'b0);
            checks++;
            if (gnt !== 4'(1 << (i % 4)))
                begin errors++; $display("FAIL rr_gnt[%0d]: got %b exp %b", i, gnt, 4'(1 << (i % 4))); end
            @(posedge clk); mdl_edge(k); #1;
            checks += 3;
            if (reg_en !== m_en) begin errors++; $display("FAIL rr_en[%0d]: got %b exp %b", i, reg_en, m_en); end
            if (reg_data !== 8'(m_data)) begin errors++; $display("FAIL rr_data[%0d]: got %h exp %h", i, reg_data, 8'(m_data)); end
            if (wr_count !== 8'(m_cnt)) begin errors++; $display("FAIL rr_cnt[%0d]: got %h exp %h", i, wr_count, 8'(m_cnt)); end
        end
    endtask

    task automatic test_hold();
        int k;
        int cnt0;
        cnt0 = m_cnt;
        new_payload();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 1'b1);
            checks++;
            if (gnt !== 4'b0000) begin errors++; $display("FAIL hold_gnt[%0d]: got %b exp 0000", i, gnt); end
            @(posedge clk); mdl_edge(-1); #1;
            checks += 3;
            if (reg_en !== 4'b0000) begin errors++; $display("FAIL hold_en[%0d]: got %b exp 0000", i, reg_en); end
            if (busy !== 1'b0) begin errors++; $display("FAIL hold_busy[%0d]: got %b exp 0", i, busy); end
            if (wr_count !== 8'(cnt0)) begin errors++; $display("FAIL hold_cnt[%0d]: got %h exp %h", i, wr_count, 8'(cnt0)); end
        end
        drive(4'b0100, 1'b0);
        k = pick(4'b0100, 1'b0);
        checks++;
        if (gnt !== 4'b0100) begin errors++; $display("FAIL hold_release_gnt: got %b exp 0100", gnt); end
        @(posedge clk); mdl_edge(k); #1;
        checks += 2;
        if (reg_en !== m_en) begin errors++; $display("FAIL hold_release_en: got %b exp %b", reg_en, m_en); end
        if (wr_count !== 8'(cnt0 + 1)) begin errors++; $display("FAIL hold_release_cnt: got %h exp %h", wr_count, 8'(cnt0 + 1)); end
    endtask

    task automatic test_ptr_idle();
        int k;
        new_payload();
        drive(4'b0001, 1'b0);
        k = pick(4'b0001, 1'b0);
        @(posedge clk); mdl_edge(k); #1;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0000, 1'b0);
            @(posedge clk); mdl_edge(-1); #1;
        end
        drive(4'b0011, 1'b0);
        k = pick(4'b0011, 1'b0);
        checks++;
        if (gnt !== 4'b0010) begin errors++; $display("FAIL ptr_idle_gnt: got %b exp 0010", gnt); end
        @(posedge clk); mdl_edge(k); #1;
    endtask

    task automatic test_wrap();
        int k;
        logic [3:0] r;
        res = 1'b0;
        #1;
        mdl_reset();
        @(posedge clk); #1;
        res = 1'b1;
        for (int i = 0; i < 256; i++) begin
            new_payload();
            r = 4'($urandom_range(1, 15));
            drive(r, 1'b0);
            k = pick(r, 1'b0);
            checks++;
            if (gnt !== oh(k)) begin errors++; $display("FAIL wrap_gnt[%0d]: got %b exp %b", i, gnt, oh(k)); end
            @(posedge clk); mdl_edge(k); #1;
            checks++;
            if (wr_count !== 8'(m_cnt)) begin errors++; $display("FAIL wrap_cnt[%0d]: got %h exp %h", i, wr_count, 8'(m_cnt)); end
        end
        checks++;
        if (wr_count !== 8'h00) begin errors++; $display("FAIL wrap_256: got %h exp 00", wr_count); end
        drive(4'b0001, 1'b0);
        k = pick(4'b0001, 1'b0);
        @(posedge clk); mdl_edge(k); #1;
        checks++;
        if (wr_count !== 8'h01) begin errors++; $display("FAIL wrap_257: got %h exp 01", wr_count); end
    endtask

    task automatic test_random();
        int k;
        logic [3:0] r;
        logic h;
        for (int i = 0; i < 200; i++) begin
            new_payload();
            r = 4'($urandom_range(0, 15));
            h = ($urandom_range(0, 3) == 0);
            drive(r, h);
            k = pick(r, h);
            checks++;
            if (gnt !== oh(k)) begin errors++; $display("FAIL rand_gnt[%0d]: got %b exp %b", i, gnt, oh(k)); end
            @(posedge clk); mdl_edge(k); #1;
            checks += 4;
            if (reg_en !== m_en) begin errors++; $display("FAIL rand_en[%0d]: got %b exp %b", i, reg_en, m_en); end
            if (reg_data !== 8'(m_data)) begin errors++; $display("FAIL rand_data[%0d]: got %h exp %h", i, reg_data, 8'(m_data)); end
            if (busy !== m_busy[0]) begin errors++; $display("FAIL rand_busy[%0d]: got %b exp %b", i, busy, m_busy[0]); end
            if (wr_count !== 8'(m_cnt)) begin errors++; $display("FAIL rand_cnt[%0d]: got %h exp %h", i, wr_count, 8'(m_cnt)); end
        end
    endtask

    initial begin
        res      = 1'b0;
        req      = '0;
        hold     = 1'b0;
        req_addr = '0;
        req_data = '0;
        #2;
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_ptr_idle();
        test_random();
        test_wrap();
        drive(4'b0000, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
